// File: rtl/pc_next_unit.sv
// Program-counter generator: sequential, PC-relative branch and absolute jump
// targets, with PC freeze on memory stall and deferred application of a redirect
// captured during the stall.
module pc_next_unit #(
  parameter int                ADDR_W    = 32,
  parameter int                OFF_W     = 8,
  parameter int                OFF_SHIFT = 2,
  parameter int                INC       = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     BUSYWAIT,
  input  logic                     BRANCH_TAKEN,
  input  logic signed [OFF_W-1:0]  BRANCH_OFFSET,
  input  logic                     JUMP,
  input  logic [ADDR_W-1:0]        JUMP_TARGET,
  output logic [ADDR_W-1:0]        PC,
  output logic                     PC_VALID,
  output logic                     PENDING
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   pend_target;
  logic [ADDR_W-1:0]   seq;
  logic [ADDR_W-1:0]   btgt;
  logic [ADDR_W-1:0]   rtgt;
  logic                redirect;

  // Sign-extend the word offset to full width, scale to bytes, add to base; wraps.
  function automatic logic [ADDR_W-1:0] branch_target(
    input logic [ADDR_W-1:0]       base,
    input logic signed [OFF_W-1:0] off
  );
    logic signed [ADDR_W-1:0] off_ext;
    off_ext = ADDR_W'(off);
    return base + $unsigned(off_ext <<< OFF_SHIFT);
  endfunction

  assign seq      = PC + ADDR_W'(INC);
  assign btgt     = branch_target(seq, BRANCH_OFFSET);
  assign redirect = JUMP | BRANCH_TAKEN;
  assign rtgt     = JUMP ? JUMP_TARGET : btgt;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      PC          <= RESET_PC;
      PC_VALID    <= 1'b0;
      PENDING     <= 1'b0;
      pend_target <= '0;
      state       <= BOOT;
    end else begin
      case (state)
        BOOT: begin
          PC_VALID <= 1'b1;
          state    <= RUN;
        end
        RUN: begin
          if (!BUSYWAIT) begin
            PC <= redirect ? rtgt : seq;
          end else if (redirect) begin
            // Target is taken from the frozen PC; the first capture wins.
            pend_target <= rtgt;
            PENDING     <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (!BUSYWAIT) begin
            PC      <= pend_target;
            PENDING <= 1'b0;
            state   <= RUN;
          end
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: directed scenarios plus a randomized run against a
// behavioural model, on a 32-bit instance and an 8-bit wrap instance.
module tb_pc_next_unit;

  logic        CLK;
  logic        rst_n, busy, br, jmp;
  logic [7:0]  off;
  logic [31:0] jtgt, pc;
  logic        pc_valid, pending;

  logic        rst8_n, busy8, br8, jmp8;
  logic [7:0]  off8, jtgt8, pc8;
  logic        valid8, pend8;

  int pass_cnt = 0;
  int total_cnt = 0;

  pc_next_unit #(.ADDR_W(32)) u_dut (
    .CLK(CLK), .RESET(rst_n), .BUSYWAIT(busy), .BRANCH_TAKEN(br),
    .BRANCH_OFFSET(off), .JUMP(jmp), .JUMP_TARGET(jtgt),
    .PC(pc), .PC_VALID(pc_valid), .PENDING(pending)
  );

  pc_next_unit #(.ADDR_W(8)) u_dut8 (
    .CLK(CLK), .RESET(rst8_n), .BUSYWAIT(busy8), .BRANCH_TAKEN(br8),
    .BRANCH_OFFSET(off8), .JUMP(jmp8), .JUMP_TARGET(jtgt8),
    .PC(pc8), .PC_VALID(valid8), .PENDING(pend8)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; busy = 1'b0; br = 1'b0; jmp = 1'b0; off = 8'h00; jtgt = 32'h0;
    #12;
    total_cnt++;
    if ({pc, pc_valid, pending} !== {32'h0, 1'b0, 1'b0})
      $display("FAIL reset_state pc=%h valid=%b pend=%b exp pc=0 valid=0 pend=0", pc, pc_valid, pending);
    else pass_cnt++;
    rst_n = 1'b1;
    step();
    total_cnt++;
    if ({pc, pc_valid, pending} !== {32'h0, 1'b1, 1'b0})
      $display("FAIL boot_exit pc=%h valid=%b pend=%b exp pc=0 valid=1 pend=0", pc, pc_valid, pending);
    else pass_cnt++;
    step();
    total_cnt++;
    if (pc !== 32'h4) $display("FAIL seq_1 pc=%h exp=%h", pc, 32'h4); else pass_cnt++;
    step();
    total_cnt++;
    if (pc !== 32'h8) $display("FAIL seq_2 pc=%h exp=%h", pc, 32'h8); else pass_cnt++;
  endtask

  task automatic test_branch();
    step();
    step();
    total_cnt++;
    if (pc !== 32'h10) $display("FAIL seq_to_10 pc=%h exp=%h", pc, 32'h10); else pass_cnt++;
    br = 1'b1; off = 8'hFE;
    step();
    total_cnt++;
    if (pc !== 32'h0C) $display("FAIL branch_neg pc=%h exp=%h", pc, 32'h0C); else pass_cnt++;
    off = 8'h03;
    step();
    total_cnt++;
    if (pc !== 32'h1C) $display("FAIL branch_pos pc=%h exp=%h", pc, 32'h1C); else pass_cnt++;
    br = 1'b0;
  endtask

  task automatic test_jump_priority();
    jmp = 1'b1; jtgt = 32'h20;
    step();
    total_cnt++;
    if (pc !== 32'h20) $display("FAIL jump_20 pc=%h exp=%h", pc, 32'h20); else pass_cnt++;
    br = 1'b1; off = 8'h05; jtgt = 32'h100;
    step();
    total_cnt++;
    if (pc !== 32'h100) $display("FAIL jump_priority pc=%h exp=%h", pc, 32'h100); else pass_cnt++;
    br = 1'b0; jmp = 1'b0;
    step();
    total_cnt++;
    if (pc !== 32'h104) $display("FAIL after_jump pc=%h exp=%h", pc, 32'h104); else pass_cnt++;
  endtask

  task automatic test_stall();
    jmp = 1'b1; jtgt = 32'h40;
    step();
    total_cnt++;
    if (pc !== 32'h40) $display("FAIL jump_40 pc=%h exp=%h", pc, 32'h40); else pass_cnt++;
    jmp = 1'b0; busy = 1'b1;
    step();
    total_cnt++;
    if ({pc, pending} !== {32'h40, 1'b0})
      $display("FAIL stall_plain pc=%h pend=%b exp pc=40 pend=0", pc, pending);
    else pass_cnt++;
    br = 1'b1; off = 8'h02;
    step();
    total_cnt++;
    if ({pc, pc_valid, pending} !== {32'h40, 1'b1, 1'b1})
      $display("FAIL stall_capture pc=%h valid=%b pend=%b exp pc=40 valid=1 pend=1", pc, pc_valid, pending);
    else pass_cnt++;
    br = 1'b0; jmp = 1'b1; jtgt = 32'h200;
    step();
    total_cnt++;
    if ({pc, pending} !== {32'h40, 1'b1})
      $display("FAIL stall_second pc=%h pend=%b exp pc=40 pend=1", pc, pending);
    else pass_cnt++;
    jmp = 1'b0;
    step();
    total_cnt++;
    if ({pc, pending} !== {32'h40, 1'b1})
      $display("FAIL stall_third pc=%h pend=%b exp pc=40 pend=1", pc, pending);
    else pass_cnt++;
    busy = 1'b0; jmp = 1'b1; jtgt = 32'h300;
    step();
    total_cnt++;
    if ({pc, pc_valid, pending} !== {32'h4C, 1'b1, 1'b0})
      $display("FAIL stall_release pc=%h valid=%b pend=%b exp pc=4c valid=1 pend=0", pc, pc_valid, pending);
    else pass_cnt++;
    jmp = 1'b0;
    step();
    total_cnt++;
    if (pc !== 32'h50) $display("FAIL after_release pc=%h exp=%h", pc, 32'h50); else pass_cnt++;
  endtask

  task automatic test_reset_pending();
    busy = 1'b1; br = 1'b1; off = 8'h07;
    step();
    total_cnt++;
    if ({pc, pending} !== {32'h50, 1'b1})
      $display("FAIL pend_before_reset pc=%h pend=%b exp pc=50 pend=1", pc, pending);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({pc, pc_valid, pending} !== {32'h0, 1'b0, 1'b0})
      $display("FAIL async_reset pc=%h valid=%b pend=%b exp pc=0 valid=0 pend=0", pc, pc_valid, pending);
    else pass_cnt++;
    jmp = 1'b1; jtgt = 32'h500;
    #2 rst_n = 1'b1;
    step();
    total_cnt++;
    if ({pc, pc_valid, pending} !== {32'h0, 1'b1, 1'b0})
      $display("FAIL boot_ignores_inputs pc=%h valid=%b pend=%b exp pc=0 valid=1 pend=0", pc, pc_valid, pending);
    else pass_cnt++;
    busy = 1'b0; br = 1'b0; jmp = 1'b0;
    step();
    total_cnt++;
    if ({pc, pending} !== {32'h4, 1'b0})
      $display("FAIL post_reset_seq1 pc=%h pend=%b exp pc=4 pend=0", pc, pending);
    else pass_cnt++;
    step();
    total_cnt++;
    if (pc !== 32'h8) $display("FAIL post_reset_seq2 pc=%h exp=%h", pc, 32'h8); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] m_pc, seq, btgt, rtgt;
    logic [31:0] pend_q[$];
    logic        exp_pend;
    int          offv;
    m_pc = 32'h8;
    for (int i = 0; i < 300; i++) begin
      busy = ($urandom_range(0, 2) == 0);
      br   = ($urandom_range(0, 3) == 0);
      jmp  = ($urandom_range(0, 5) == 0);
      off  = 8'($urandom);
      jtgt = $urandom;
      offv = int'(off);
      if (offv > 127) offv = offv - 256;
      seq  = m_pc + 32'd4;
      btgt = seq + 32'(offv * 4);
      rtgt = jmp ? jtgt : btgt;
      if (pend_q.size() != 0) begin
        if (!busy) m_pc = pend_q.pop_front();
      end else if (busy) begin
        if (br || jmp) pend_q.push_back(rtgt);
      end else begin
        m_pc = (br || jmp) ? rtgt : seq;
      end
      exp_pend = (pend_q.size() != 0);
      step();
      total_cnt++;
      if ({pc, pc_valid, pending} !== {m_pc, 1'b1, exp_pend})
        $display("FAIL random_%0d pc=%h valid=%b pend=%b exp pc=%h valid=1 pend=%b",
                 i, pc, pc_valid, pending, m_pc, exp_pend);
      else pass_cnt++;
    end
    busy = 1'b0; br = 1'b0; jmp = 1'b0;
  endtask

  task automatic test_wrap();
    rst8_n = 1'b1;
    step();
    total_cnt++;
    if ({pc8, valid8, pend8} !== {8'h00, 1'b1, 1'b0})
      $display("FAIL w8_boot pc=%h valid=%b pend=%b exp pc=00 valid=1 pend=0", pc8, valid8, pend8);
    else pass_cnt++;
    jmp8 = 1'b1; jtgt8 = 8'hFC;
    step();
    total_cnt++;
    if (pc8 !== 8'hFC) $display("FAIL w8_jump pc=%h exp=%h", pc8, 8'hFC); else pass_cnt++;
    jmp8 = 1'b0;
    step();
    total_cnt++;
    if (pc8 !== 8'h00) $display("FAIL w8_seq_wrap pc=%h exp=%h", pc8, 8'h00); else pass_cnt++;
    br8 = 1'b1; off8 = 8'h80;
    step();
    total_cnt++;
    if (pc8 !== 8'h04) $display("FAIL w8_branch_min pc=%h exp=%h", pc8, 8'h04); else pass_cnt++;
    br8 = 1'b0;
  endtask

  initial begin
    rst8_n = 1'b0; busy8 = 1'b0; br8 = 1'b0; jmp8 = 1'b0; off8 = 8'h00; jtgt8 = 8'h00;
    test_reset();
    test_branch();
    test_jump_priority();
    test_stall();
    test_reset_pending();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Parametrised program-counter generator; successor to the two-input PC/PC+offset selector.
- Owns the PC register and selects among sequential, PC-relative branch, and absolute jump targets.
- Freezes the PC while the memory hierarchy asserts BUSYWAIT.
- A redirect that arrives during a stall is captured and applied when the stall clears.
- Sits between the decode/ALU branch logic and the instruction cache address port.

Parameters:
- ADDR_W, 32: PC and target width.
- OFF_W, 8: width of the signed branch offset.
- OFF_SHIFT, 2: left shift applied to the offset (word units to byte address).
- INC, 4: sequential increment.
- RESET_PC, 0: PC value on reset.

Ports:
- CLK, input, 1: rising-edge clock.
- RESET, input, 1: asynchronous, active-low reset.
- BUSYWAIT, input, 1: memory stall; 1 = hold the PC.
- BRANCH_TAKEN, input, 1: take the PC-relative branch this cycle.
- BRANCH_OFFSET, input, OFF_W: signed offset, two's complement.
- JUMP, input, 1: take the absolute jump this cycle.
- JUMP_TARGET, input, ADDR_W: absolute jump address.
- PC, output, ADDR_W: current fetch address.
- PC_VALID, output, 1: PC is a fetchable address.
- PENDING, output, 1: a captured redirect is waiting for the stall to end.

Behaviour:
- Reset (RESET=0, asynchronous, any state): PC=RESET_PC, PC_VALID=0, PENDING=0, internal pend_target=0, state=BOOT. Reset takes effect immediately, including mid-stall or with a redirect pending; the pending redirect is discarded.
- Definitions:
  - seq = PC + INC, modulo 2^ADDR_W.
  - btgt = seq + (sign_extend(BRANCH_OFFSET) << OFF_SHIFT), modulo 2^ADDR_W.
  - redirect = JUMP | BRANCH_TAKEN.
  - rtgt = JUMP ? JUMP_TARGET : btgt. JUMP has priority when both are asserted.
- State BOOT:
  - First rising edge with RESET=1: PC unchanged (RESET_PC), PC_VALID<=1, go to RUN.
  - Redirect inputs are ignored in BOOT.
- State RUN, BUSYWAIT=0: PC<=rtgt if redirect, else PC<=seq.
- State RUN, BUSYWAIT=1:
  - PC holds.
  - If redirect: pend_target<=rtgt, computed from the held PC; PENDING<=1; go to HOLD.
  - Else stay in RUN.
- State HOLD, BUSYWAIT=1:
  - PC and pend_target hold.
  - Further redirect inputs are ignored: the first captured redirect wins.
- State HOLD, BUSYWAIT=0:
  - PC<=pend_target, PENDING<=0, go to RUN.
  - Redirect inputs in this cycle are ignored; the upstream stage is expected to have been flushed.
- Latency:
  - Redirect without a stall reaches PC one edge after it is sampled.
  - Redirect captured during a stall reaches PC on the first edge where BUSYWAIT=0.
- PC_VALID stays 1 in RUN and HOLD; it returns to 0 only on reset.
- Arithmetic: all additions wrap silently modulo 2^ADDR_W; there is no overflow flag.
- Negative offsets sign-extend from bit OFF_W-1.
- BUSYWAIT in BOOT is ignored: BOOT always exits after one edge.
- All outputs are registered, with no combinational path from inputs to PC.

Test Plan:
1. Assert RESET=0, release it before an edge, then run 3 edges with no redirect, BUSYWAIT=0. Required: PC=0,0,4,8; PC_VALID 0 until the first edge, then 1.
2. At PC=0x10, BRANCH_TAKEN=1 with OFFSET=0xFE (-2), OFF_SHIFT=2. Required: next PC = 0x10+4-8 = 0x0C. Then OFFSET=0x03 at PC=0x0C. Required: PC=0x1C.
3. At PC=0x20, JUMP=1, JUMP_TARGET=0x100, and BRANCH_TAKEN=1 with OFFSET=5 in the same cycle. Required: PC=0x100 (jump wins).
4. At PC=0x40, hold BUSYWAIT=1 for 3 cycles; branch OFFSET=2 in the 1st cycle, JUMP to 0x200 in the 2nd. Required:
   - PENDING=1 and PC=0x40 throughout the stall.
   - On the first edge with BUSYWAIT=0, PC=0x4C (first redirect wins) and PENDING=0.
5. Set ADDR_W=8 with PC=0xFC and no redirect. Required: PC wraps to 0x00. Then branch OFFSET=0x80 at PC=0x00. Required: PC=0x04-0x200, truncated to 8 bits = 0x04.
6. With PENDING=1 during a stall, pulse RESET=0 between edges. Required: PC=RESET_PC, PENDING=0, PC_VALID=0 immediately; after release, BOOT then sequential fetch from RESET_PC.
